// File: rtl/alu_cmd_sequencer.sv
// Command-side master for the 16-bit ALU: queues commands, issues them one at a
// time, captures the registered result and returns it on a valid/ready response port.
module alu_cmd_sequencer #(
  parameter int CMD_DEPTH = 4,
  parameter int NUM_OPS   = 12
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_op,
  input  logic [15:0] cmd_a,
  input  logic [15:0] cmd_b,
  input  logic        cmd_use_acc,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic        rsp_zero,
  output logic        rsp_carry,
  output logic        rsp_overflow,
  output logic        rsp_err,
  output logic        alu_enable,
  output logic [3:0]  alu_op_code,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  input  logic [15:0] alu_result,
  input  logic        alu_zero_flag,
  input  logic        alu_carry_flag,
  input  logic        alu_overflow_flag,
  output logic        busy,
  output logic [15:0] op_count
);

  localparam int PTR_W = $clog2(CMD_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } state_t;

  typedef struct packed {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        use_acc;
  } cmd_entry_t;

  cmd_entry_t             fifo_mem_r [CMD_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_r;
  logic [PTR_W-1:0]       rd_ptr_r;
  logic [CNT_W-1:0]       count_r;
  state_t                 state_r;
  logic [15:0]            acc_r;
  logic [15:0]            op_count_r;
  logic                   rsp_valid_r;
  logic [15:0]            rsp_result_r;
  logic                   rsp_zero_r;
  logic                   rsp_carry_r;
  logic                   rsp_overflow_r;
  logic                   rsp_err_r;
  logic                   alu_enable_r;
  logic [3:0]             alu_op_code_r;
  logic [15:0]            alu_a_r;
  logic [15:0]            alu_b_r;

  logic       full_s;
  logic       empty_s;
  logic       push_s;
  logic       pop_s;
  logic       illegal_s;
  cmd_entry_t head_s;

  assign full_s    = (count_r == CNT_W'(CMD_DEPTH));
  assign empty_s   = (count_r == {CNT_W{1'b0}});
  assign push_s    = cmd_valid && !full_s;
  assign pop_s     = (state_r == ST_IDLE) && !empty_s;
  assign head_s    = fifo_mem_r[rd_ptr_r];
  assign illegal_s = ({1'b0, head_s.op} >= 5'(NUM_OPS));

  // Command storage; data needs no reset because the occupancy count gates it.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= '{op: cmd_op, a: cmd_a, b: cmd_b, use_acc: cmd_use_acc};
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally as depth is a power of 2.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Sequencing FSM with all ALU-side and response-side outputs registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r        <= ST_IDLE;
      acc_r          <= 16'h0000;
      op_count_r     <= 16'h0000;
      rsp_valid_r    <= 1'b0;
      rsp_result_r   <= 16'h0000;
      rsp_zero_r     <= 1'b0;
      rsp_carry_r    <= 1'b0;
      rsp_overflow_r <= 1'b0;
      rsp_err_r      <= 1'b0;
      alu_enable_r   <= 1'b0;
      alu_op_code_r  <= 4'h0;
      alu_a_r        <= 16'h0000;
      alu_b_r        <= 16'h0000;
    end else begin
      case (state_r)
        ST_IDLE: begin
          alu_enable_r <= 1'b0;
          if (pop_s) begin
            alu_op_code_r <= head_s.op;
            alu_b_r       <= head_s.b;
            alu_a_r       <= head_s.use_acc ? acc_r : head_s.a;
            if (illegal_s) begin
              rsp_result_r   <= 16'h0000;
              rsp_zero_r     <= 1'b0;
              rsp_carry_r    <= 1'b0;
              rsp_overflow_r <= 1'b0;
              rsp_err_r      <= 1'b1;
              rsp_valid_r    <= 1'b1;
              state_r        <= ST_RESP;
            end else begin
              alu_enable_r <= 1'b1;
              state_r      <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          alu_enable_r <= 1'b0;
          state_r      <= ST_CAPTURE;
        end
        // ALU output registers hold this command's result in this cycle.
        ST_CAPTURE: begin
          alu_enable_r   <= 1'b0;
          rsp_result_r   <= alu_result;
          rsp_zero_r     <= alu_zero_flag;
          rsp_carry_r    <= alu_carry_flag;
          rsp_overflow_r <= alu_overflow_flag;
          rsp_err_r      <= 1'b0;
          rsp_valid_r    <= 1'b1;
          acc_r          <= alu_result;
          op_count_r     <= op_count_r + 16'd1;
          state_r        <= ST_RESP;
        end
        ST_RESP: begin
          alu_enable_r <= 1'b0;
          if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
            state_r     <= ST_IDLE;
          end
        end
        default: begin
          alu_enable_r <= 1'b0;
          rsp_valid_r  <= 1'b0;
          state_r      <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready    = !full_s;
  assign busy         = !empty_s || (state_r != ST_IDLE);
  assign op_count     = op_count_r;
  assign rsp_valid    = rsp_valid_r;
  assign rsp_result   = rsp_result_r;
  assign rsp_zero     = rsp_zero_r;
  assign rsp_carry    = rsp_carry_r;
  assign rsp_overflow = rsp_overflow_r;
  assign rsp_err      = rsp_err_r;
  assign alu_enable   = alu_enable_r;
  assign alu_op_code  = alu_op_code_r;
  assign alu_a        = alu_a_r;
  assign alu_b        = alu_b_r;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Randomized self-checking bench for alu_cmd_sequencer with a behavioural ALU
// and an in-order response model computed at command acceptance.
module tb_alu_cmd_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid, cmd_ready, cmd_use_acc;
  logic [3:0]  cmd_op;
  logic [15:0] cmd_a, cmd_b;
  logic        rsp_valid, rsp_ready, rsp_zero, rsp_carry, rsp_overflow, rsp_err;
  logic [15:0] rsp_result;
  logic        alu_enable;
  logic [3:0]  alu_op_code;
  logic [15:0] alu_a, alu_b, alu_result;
  logic        alu_zero_flag, alu_carry_flag, alu_overflow_flag;
  logic        busy;
  logic [15:0] op_count;

  alu_cmd_sequencer #(.CMD_DEPTH(4), .NUM_OPS(12)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_zero(rsp_zero), .rsp_carry(rsp_carry), .rsp_overflow(rsp_overflow),
    .rsp_err(rsp_err), .alu_enable(alu_enable), .alu_op_code(alu_op_code),
    .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .alu_zero_flag(alu_zero_flag), .alu_carry_flag(alu_carry_flag),
    .alu_overflow_flag(alu_overflow_flag), .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Behavioural ALU: returns {zero, carry, overflow, result[15:0]}.
  function automatic logic [18:0] alu_calc(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [16:0] w;
    logic [31:0] p;
    logic [15:0] r;
    logic c, o;
    c = 1'b0; o = 1'b0; r = 16'h0;
    case (op)
      4'd0: begin w = {1'b0, a} + {1'b0, b}; r = w[15:0]; c = w[16];
                  o = (a[15] == b[15]) && (r[15] != a[15]); end
      4'd1: begin w = {1'b0, a} - {1'b0, b}; r = w[15:0]; c = (a < b);
                  o = (a[15] != b[15]) && (r[15] != a[15]); end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = ~a;
      4'd6: begin p = {16'h0, a} << b[3:0]; r = p[15:0]; c = |p[31:16]; end
      4'd7: r = a >> b[3:0];
      4'd8: r = {15'h0, a == b};
      4'd9: r = {15'h0, a < b};
      4'd10: r = {15'h0, a <= b};
      4'd11: begin p = a * b; r = p[15:0]; c = |p[31:16]; o = |p[31:16]; end
      default: r = 16'h0;
    endcase
    return {(r == 16'h0), c, o, r};
  endfunction

  always_ff @(posedge clk) begin
    if (alu_enable) {alu_zero_flag, alu_carry_flag, alu_overflow_flag, alu_result} <= alu_calc(alu_op_code, alu_a, alu_b);
  end

  // Reference model state: {op_count16, err, zero, carry, ovf, result16} and {op, a, b}.
  logic [35:0] exp_rsp_q[$];
  logic [35:0] exp_alu_q[$];
  logic [15:0] acc_m = 16'h0;
  logic [15:0] opcnt_m = 16'h0;
  bit          mon_en = 1'b0;
  int          en_cnt = 0;
  logic [15:0] last_result;
  logic [3:0]  last_flags;   // {err, zero, carry, ovf}
  bit          prev_en = 1'b0;
  bit          hold = 1'b0;
  logic [19:0] held;

  task automatic model_accept(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b, input logic ua);
    logic [15:0] a_eff;
    logic [18:0] r;
    if (op >= 4'd12) begin
      exp_rsp_q.push_back({opcnt_m, 1'b1, 3'b000, 16'h0000});
    end else begin
      a_eff = ua ? acc_m : a;
      r = alu_calc(op, a_eff, b);
      acc_m = r[15:0];
      opcnt_m = opcnt_m + 16'd1;
      exp_alu_q.push_back({op, a_eff, b});
      exp_rsp_q.push_back({opcnt_m, 1'b0, r[18:16], r[15:0]});
    end
  endtask

  // Monitor: inputs change #1 after posedge, so negedge shows what the next edge does.
  always @(negedge clk) begin
    logic [35:0] e;
    if (mon_en) begin
      if (hold && rsp_valid) chk("rsp_stable", {12'h0, rsp_err, rsp_zero, rsp_carry, rsp_overflow, rsp_result}, {12'h0, held});
      hold = rsp_valid && !rsp_ready;
      held = {rsp_err, rsp_zero, rsp_carry, rsp_overflow, rsp_result};
      if (alu_enable) begin
        en_cnt++;
        chk("en_single_cycle", {31'h0, prev_en}, 32'h0);
        if (exp_alu_q.size() == 0) chk("alu_unexpected", 32'h1, 32'h0);
        else begin
          e = exp_alu_q.pop_front();
          chk("alu_op", {28'h0, alu_op_code}, {28'h0, e[35:32]});
          chk("alu_a", {16'h0, alu_a}, {16'h0, e[31:16]});
          chk("alu_b", {16'h0, alu_b}, {16'h0, e[15:0]});
        end
      end
      prev_en = alu_enable;
      if (rsp_valid && rsp_ready) begin
        if (exp_rsp_q.size() == 0) chk("rsp_unexpected", 32'h1, 32'h0);
        else begin
          e = exp_rsp_q.pop_front();
          chk("rsp_result", {16'h0, rsp_result}, {16'h0, e[15:0]});
          chk("rsp_flags", {28'h0, rsp_err, rsp_zero, rsp_carry, rsp_overflow}, {28'h0, e[19:16]});
          chk("op_count", {16'h0, op_count}, {16'h0, e[35:20]});
        end
        last_result = rsp_result;
        last_flags  = {rsp_err, rsp_zero, rsp_carry, rsp_overflow};
      end
      if (cmd_valid && cmd_ready) model_accept(cmd_op, cmd_a, cmd_b, cmd_use_acc);
    end
  end

  bit rnd_ready = 1'b0;
  always begin
    @(posedge clk); #1;
    if (rnd_ready) rsp_ready = ($urandom_range(0, 2) != 0);
  end

  task automatic align();
    @(posedge clk); #1;
  endtask

  // Present one command (caller is at posedge+1) and hold it until accepted.
  task automatic send(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b, input logic ua);
    int  t;
    bit  ok;
    t = 0; ok = 1'b0;
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_use_acc = ua;
    do begin
      @(negedge clk);
      ok = cmd_ready;
      t++;
      if (!ok) begin @(posedge clk); #1; end
    end while (!ok && t < 300);
    if (!ok) chk("cmd_timeout", 32'h0, 32'h1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int t;
    t = 0;
    do begin @(negedge clk); t++; end
    while ((busy || rsp_valid || exp_rsp_q.size() != 0) && t < budget);
    if (busy || rsp_valid || exp_rsp_q.size() != 0) chk("idle_timeout", 32'h0, 32'h1);
    align();
  endtask

  initial begin
    int k;
    int en0;
    logic [15:0] cnt0;
    bit seen;
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_op = 4'h0; cmd_a = 16'h0; cmd_b = 16'h0;
    cmd_use_acc = 1'b0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst_alu_enable", {31'h0, alu_enable}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_cmd_ready", {31'h0, cmd_ready}, 32'h1);
    chk("rst_op_count", {16'h0, op_count}, 32'h0);
    @(negedge clk); reset_n = 1'b1; mon_en = 1'b1;
    align();

    // ADD 0x7FFF + 1 and latency from the push edge.
    cmd_valid = 1'b1; cmd_op = 4'd0; cmd_a = 16'h7FFF; cmd_b = 16'h0001; cmd_use_acc = 1'b0;
    @(posedge clk); #1; cmd_valid = 1'b0;
    k = 0;
    while (!rsp_valid && k < 10) begin @(posedge clk); #1; k++; end
    chk("latency_legal", k, 32'd3);
    wait_idle(50);
    chk("add_result", {16'h0, last_result}, 32'h8000);
    chk("add_flags", {28'h0, last_flags}, {28'h0, 4'b0001});
    chk("add_op_count", {16'h0, op_count}, 32'd1);
    chk("add_en_count", en_cnt, 32'd1);

    // Illegal op leaves accumulator and op_count alone.
    en0 = en_cnt; cnt0 = op_count;
    cmd_valid = 1'b1; cmd_op = 4'hC; cmd_a = 16'h1234; cmd_b = 16'h0; cmd_use_acc = 1'b0;
    @(posedge clk); #1; cmd_valid = 1'b0;
    k = 0;
    while (!rsp_valid && k < 10) begin @(posedge clk); #1; k++; end
    chk("latency_illegal", k, 32'd1);
    wait_idle(50);
    chk("ill_result", {16'h0, last_result}, 32'h0);
    chk("ill_flags", {28'h0, last_flags}, {28'h0, 4'b1000});
    chk("ill_no_enable", en_cnt, en0);
    chk("ill_op_count", {16'h0, op_count}, {16'h0, cnt0});
    send(4'd0, 16'hFFFF, 16'h0001, 1'b1);
    wait_idle(50);
    chk("acc_kept", {16'h0, last_result}, 32'h8001);

    // Chain: ADD 5+3 then SUB acc-8.
    send(4'd0, 16'h0005, 16'h0003, 1'b0);
    send(4'd1, 16'hAAAA, 16'h0008, 1'b1);
    wait_idle(50);
    chk("chain_result", {16'h0, last_result}, 32'h0);
    chk("chain_flags", {28'h0, last_flags}, {28'h0, 4'b0100});

    // MUL overflow into zero.
    send(4'd11, 16'h0100, 16'h0100, 1'b0);
    wait_idle(50);
    chk("mul_result", {16'h0, last_result}, 32'h0);
    chk("mul_flags", {28'h0, last_flags}, {28'h0, 4'b0111});

    // Backpressure: one in RESP, four queued, sixth refused.
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(4'(i), 16'(i * 16'h0111 + 16'h0007), 16'(i + 1), 1'b0);
    cmd_valid = 1'b1; cmd_op = 4'd4; cmd_a = 16'h5555; cmd_b = 16'h0F0F; cmd_use_acc = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("full_cmd_ready", {31'h0, cmd_ready}, 32'h0);
      chk("full_busy", {31'h0, busy}, 32'h1);
    end
    @(posedge clk); #1; cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    wait_idle(100);

    // Reset while the first of three commands is in CAPTURE.
    send(4'd0, 16'h0011, 16'h0022, 1'b0);
    send(4'd2, 16'h00FF, 16'h0F0F, 1'b0);
    send(4'd3, 16'h1000, 16'h0001, 1'b0);
    mon_en = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("mid_rst_alu_a", {16'h0, alu_a}, 32'h0);
    chk("mid_rst_op_count", {16'h0, op_count}, 32'h0);
    chk("mid_rst_busy", {31'h0, busy}, 32'h0);
    exp_rsp_q.delete(); exp_alu_q.delete();
    acc_m = 16'h0; opcnt_m = 16'h0; hold = 1'b0; prev_en = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rsp_valid || alu_enable) seen = 1'b1;
    end
    chk("post_rst_quiet", {31'h0, seen}, 32'h0);
    chk("post_rst_busy", {31'h0, busy}, 32'h0);
    mon_en = 1'b1;
    align();

    // Random traffic with random response backpressure.
    rnd_ready = 1'b1;
    for (int i = 0; i < 80; i++) begin
      send(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 6)) align();
    end
    rnd_ready = 1'b0;
    @(posedge clk); #2; rsp_ready = 1'b1;
    wait_idle(1000);
    chk("rand_op_count", {16'h0, op_count}, {16'h0, opcnt_m});
    chk("rand_alu_q_empty", exp_alu_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
